// File: rtl/semi_executor_pkg.sv
// Shared car-simulation definitions: command codes, executor FSM states and timer width.
// Imported by the semi-command stage and the semi-auto executor.
package semi_executor_pkg;

    localparam int unsigned CNT_W = 28;

    typedef enum logic [1:0] {
        CmdNone     = 2'b00,
        CmdStraight = 2'b01,
        CmdTurn90   = 2'b10,
        CmdUTurn    = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCruise  = 3'd1,
        StWaitCmd = 3'd2,
        StTurn    = 3'd3,
        StLeave   = 3'd4
    } state_e;

    // Detectors read 1 for a wall; an open side or a wall ahead marks a junction.
    function automatic logic is_junction(input logic front, input logic left, input logic right);
        return front || !left || !right;
    endfunction

endpackage

// File: rtl/manoeuvre_timer.sv
// Saturating down-counter timing one manoeuvre; reusable by any mode.
// done flags the last counted cycle so the owner can leave on that edge.
import semi_executor_pkg::*;

module manoeuvre_timer #(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q <= WIDTH'(1));

endmodule

// File: rtl/semi_executor.sv
// Semi-auto executor: cruises to a junction, waits for a command, then turns and/or
// drives forward to clear the junction. All outputs are registered from the next state.
import semi_executor_pkg::*;

module semi_executor #(
    parameter int unsigned TURN_CYCLES  = 90_000_000,
    parameter int unsigned LEAVE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] cmd,
    input  logic       clockwise,
    input  logic       det_front,
    input  logic       det_left,
    input  logic       det_right,
    output logic       cmd_ready,
    output logic       move_forward,
    output logic       turn_left,
    output logic       turn_right,
    output logic       at_junction
);

    localparam logic [CNT_W-1:0] TurnLoad  = CNT_W'(TURN_CYCLES);
    localparam logic [CNT_W-1:0] UTurnLoad = CNT_W'(2 * TURN_CYCLES);
    localparam logic [CNT_W-1:0] LeaveLoad = CNT_W'(LEAVE_CYCLES);

    state_e           state_q, state_d;
    logic             dir_q, dir_d;
    logic             tmr_load, tmr_count, tmr_done;
    logic [CNT_W-1:0] tmr_value;

    logic cmd_ready_q, move_forward_q, turn_left_q, turn_right_q, at_junction_q;
    logic cmd_ready_d, move_forward_d, turn_left_d, turn_right_d, at_junction_d;

    manoeuvre_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load),
        .load_value (tmr_value),
        .count      (tmr_count),
        .done       (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        tmr_load  = 1'b0;
        tmr_value = '0;
        tmr_count = 1'b0;
        if (!enable) begin
            // Leaving semi-auto mode wipes any manoeuvre in progress.
            state_d  = StIdle;
            dir_d    = 1'b0;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: state_d = StCruise;
                StCruise: begin
                    if (is_junction(det_front, det_left, det_right)) begin
                        state_d = StWaitCmd;
                    end
                end
                StWaitCmd: begin
                    unique case (cmd_e'(cmd))
                        CmdNone: ;
                        CmdStraight: begin
                            state_d   = StLeave;
                            dir_d     = clockwise;
                            tmr_load  = 1'b1;
                            tmr_value = LeaveLoad;
                        end
                        CmdTurn90: begin
                            state_d   = StTurn;
                            dir_d     = clockwise;
                            tmr_load  = 1'b1;
                            tmr_value = TurnLoad;
                        end
                        CmdUTurn: begin
                            state_d   = StTurn;
                            dir_d     = clockwise;
                            tmr_load  = 1'b1;
                            tmr_value = UTurnLoad;
                        end
                    endcase
                end
                StTurn: begin
                    if (tmr_done) begin
                        state_d   = StLeave;
                        tmr_load  = 1'b1;
                        tmr_value = LeaveLoad;
                    end else begin
                        tmr_count = 1'b1;
                    end
                end
                StLeave: begin
                    // Side detectors still see the junction being cleared, so only
                    // a wall ahead matters here.
                    if (det_front) begin
                        state_d  = StWaitCmd;
                        tmr_load = 1'b1;
                    end else if (tmr_done) begin
                        state_d = StCruise;
                    end else begin
                        tmr_count = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cmd_ready_d    = (state_d == StWaitCmd);
        move_forward_d = (state_d == StCruise) || (state_d == StLeave);
        turn_left_d    = (state_d == StTurn) && !dir_d;
        turn_right_d   = (state_d == StTurn) && dir_d;
        at_junction_d  = (state_d == StWaitCmd) || (state_d == StTurn) || (state_d == StLeave);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            dir_q          <= 1'b0;
            cmd_ready_q    <= 1'b0;
            move_forward_q <= 1'b0;
            turn_left_q    <= 1'b0;
            turn_right_q   <= 1'b0;
            at_junction_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            cmd_ready_q    <= cmd_ready_d;
            move_forward_q <= move_forward_d;
            turn_left_q    <= turn_left_d;
            turn_right_q   <= turn_right_d;
            at_junction_q  <= at_junction_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign move_forward = move_forward_q;
    assign turn_left    = turn_left_q;
    assign turn_right   = turn_right_q;
    assign at_junction  = at_junction_q;

endmodule

// File: tb/tb_semi_executor.sv
// Bench for semi_executor: directed manoeuvre scenarios plus random stimulus, all
// checked cycle by cycle against a mode/remaining-time reference model.
module tb_semi_executor;

    localparam int T = 4;
    localparam int L = 3;

    localparam int MIdle   = 0;
    localparam int MCruise = 1;
    localparam int MWait   = 2;
    localparam int MTurn   = 3;
    localparam int MLeave  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       clockwise = 1'b0;
    logic       det_front = 1'b0;
    logic       det_left = 1'b1;
    logic       det_right = 1'b1;
    logic       cmd_ready, move_forward, turn_left, turn_right, at_junction;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mode = MIdle;
    int m_rem  = 0;
    bit m_dir  = 1'b0;

    semi_executor #(
        .TURN_CYCLES  (T),
        .LEAVE_CYCLES (L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cmd          (cmd),
        .clockwise    (clockwise),
        .det_front    (det_front),
        .det_left     (det_left),
        .det_right    (det_right),
        .cmd_ready    (cmd_ready),
        .move_forward (move_forward),
        .turn_left    (turn_left),
        .turn_right   (turn_right),
        .at_junction  (at_junction)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: what the car should be doing, and how many cycles of it remain.
    task automatic model_step();
        if (rst || !enable) begin
            m_mode = MIdle;
            m_rem  = 0;
            m_dir  = 1'b0;
        end else begin
            case (m_mode)
                MIdle:   m_mode = MCruise;
                MCruise: if (det_front || !det_left || !det_right) m_mode = MWait;
                MWait: begin
                    if (cmd != 2'b00) begin
                        m_dir = clockwise;
                        if (cmd == 2'b01) begin
                            m_mode = MLeave;
                            m_rem  = L;
                        end else begin
                            m_mode = MTurn;
                            m_rem  = (cmd == 2'b10) ? T : 2 * T;
                        end
                    end
                end
                MTurn: begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_mode = MLeave;
                        m_rem  = L;
                    end
                end
                MLeave: begin
                    if (det_front) begin
                        m_mode = MWait;
                    end else begin
                        m_rem--;
                        if (m_rem == 0) m_mode = MCruise;
                    end
                end
                default: m_mode = MIdle;
            endcase
        end
    endtask

    function automatic logic [4:0] model_outs();
        logic [4:0] o;
        o[4] = (m_mode == MWait);
        o[3] = (m_mode == MCruise) || (m_mode == MLeave);
        o[2] = (m_mode == MTurn) && !m_dir;
        o[1] = (m_mode == MTurn) && m_dir;
        o[0] = (m_mode == MWait) || (m_mode == MTurn) || (m_mode == MLeave);
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("outputs", {27'd0, cmd_ready, move_forward, turn_left, turn_right, at_junction},
                 {27'd0, model_outs()});
    endtask

    // Walk a manoeuvre until plain cruising, tallying motion cycles seen.
    task automatic run_count(output int tr, output int tl, output int lv);
        tr = 0;
        tl = 0;
        lv = 0;
        for (int i = 0; i < 40; i++) begin
            if (turn_right) tr++;
            if (turn_left) tl++;
            if (move_forward && at_junction) lv++;
            if (move_forward && !at_junction) return;
            tick();
        end
        check_eq("run_timeout", 32'd1, 32'd0);
    endtask

    int tr, tl, lv;

    initial begin
        // Reset held two cycles with enable already high.
        enable = 1'b1;
        tick();
        tick();
        check_eq("reset_outs", {27'd0, cmd_ready, move_forward, turn_left, turn_right,
                 at_junction}, 32'd0);
        #3 rst = 1'b0;
        tick();
        tick();
        check_eq("cruise_mf", {31'd0, move_forward}, 32'd1);
        check_eq("cruise_rdy", {31'd0, cmd_ready}, 32'd0);

        // Open left side -> wait, then right turn.
        det_left = 1'b0;
        tick();
        det_left = 1'b1;
        check_eq("wait_rdy", {31'd0, cmd_ready}, 32'd1);
        check_eq("wait_mf", {31'd0, move_forward}, 32'd0);
        cmd = 2'b10;
        clockwise = 1'b1;
        tick();
        cmd = 2'b00;
        clockwise = 1'b0;
        run_count(tr, tl, lv);
        check_eq("t90_right", tr, 32'd4);
        check_eq("t90_left", tl, 32'd0);
        check_eq("t90_leave", lv, 32'd3);

        // U-turn left; direction flip mid-turn and open left side during leave ignored.
        det_left = 1'b0;
        tick();
        check_eq("wait2_rdy", {31'd0, cmd_ready}, 32'd1);
        cmd = 2'b11;
        clockwise = 1'b0;
        tick();
        cmd = 2'b00;
        clockwise = 1'b1;
        run_count(tr, tl, lv);
        check_eq("ut_left", tl, 32'd8);
        check_eq("ut_right", tr, 32'd0);
        check_eq("ut_leave", lv, 32'd3);
        tick();
        det_left = 1'b1;
        check_eq("wait3_rdy", {31'd0, cmd_ready}, 32'd1);

        // Straight, then wall ahead on the second leave cycle.
        cmd = 2'b01;
        tick();
        cmd = 2'b00;
        tick();
        det_front = 1'b1;
        tick();
        det_front = 1'b0;
        check_eq("abort_rdy", {31'd0, cmd_ready}, 32'd1);
        check_eq("abort_mf", {31'd0, move_forward}, 32'd0);

        // Drop enable mid-turn, then re-enable and take a full-length turn.
        cmd = 2'b10;
        clockwise = 1'b0;
        tick();
        cmd = 2'b00;
        tick();
        enable = 1'b0;
        tick();
        check_eq("dis_outs", {27'd0, cmd_ready, move_forward, turn_left, turn_right,
                 at_junction}, 32'd0);
        enable = 1'b1;
        tick();
        check_eq("reen_mf", {31'd0, move_forward}, 32'd1);
        det_right = 1'b0;
        tick();
        det_right = 1'b1;
        cmd = 2'b10;
        clockwise = 1'b1;
        tick();
        cmd = 2'b00;
        run_count(tr, tl, lv);
        check_eq("reen_right", tr, 32'd4);
        check_eq("reen_leave", lv, 32'd3);

        // Reset mid-leave while enable stays high.
        det_front = 1'b1;
        tick();
        det_front = 1'b0;
        cmd = 2'b01;
        tick();
        cmd = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        check_eq("rst_leave", {27'd0, cmd_ready, move_forward, turn_left, turn_right,
                 at_junction}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("post_rst_mf", {31'd0, move_forward}, 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            enable    = ($urandom_range(0, 59) != 0);
            cmd       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) cmd = 2'b00;
            clockwise = 1'($urandom_range(0, 1));
            det_front = ($urandom_range(0, 9) == 0);
            det_left  = ($urandom_range(0, 5) != 0);
            det_right = ($urandom_range(0, 5) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/semi_executor.md
SEMI_EXECUTOR -- requirements
Module: semi_executor

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 90_000_000, meaning clock cycles for one 90-degree turn (0.9 s at 100 MHz).
REQ-002 SHALL have parameter LEAVE_CYCLES, default 50_000_000, meaning forward cycles to clear a junction before junction detection re-arms.
REQ-003 SHALL have port clk, input, 1, system clock; single clock domain.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port enable, input, 1, semi-auto mode active.
REQ-006 SHALL have port cmd, input, 2, command from the semi-command stage: 00 none, 01 straight, 10 turn 90, 11 U-turn.
REQ-007 SHALL have port clockwise, input, 1, turn direction for cmd 10/11: 1 right, 0 left.
REQ-008 SHALL have ports det_front, det_left, det_right, input, 1 each, detectors (1 = wall present).
REQ-009 SHALL have port cmd_ready, output, 1, high only in WAIT_CMD; a command is accepted when cmd_ready=1 and cmd!=00.
REQ-010 SHALL have ports move_forward, turn_left, turn_right, output, 1 each, motion requests to the car model; at most one high at a time.
REQ-011 SHALL have port at_junction, output, 1, high in WAIT_CMD, TURN and LEAVE.

Function
REQ-012 SHALL implement a 5-state FSM: IDLE, CRUISE, WAIT_CMD, TURN, LEAVE.
REQ-013 All outputs SHALL be registered; each takes its state-implied value on the cycle after the state is entered.
REQ-014 IDLE: all outputs 0; enable=1 -> CRUISE.
REQ-015 CRUISE: move_forward=1; on a sampled junction (det_front=1 or det_left=0 or det_right=0) -> WAIT_CMD next cycle.
REQ-016 WAIT_CMD: motion outputs 0, cmd_ready=1; cmd=01 -> LEAVE; cmd=10 -> TURN with target TURN_CYCLES; cmd=11 -> TURN with target 2*TURN_CYCLES; cmd=00 -> stay.
REQ-017 direction (clockwise) SHALL be latched on acceptance; later changes of cmd/clockwise SHALL be ignored until WAIT_CMD is re-entered.
REQ-018 TURN: turn_right=1 if latched clockwise else turn_left=1, for exactly the target count of cycles, then -> LEAVE.
REQ-019 LEAVE: move_forward=1 for exactly LEAVE_CYCLES cycles, then -> CRUISE; det_left/det_right ignored in LEAVE.
REQ-020 LEAVE: det_front=1 SHALL abort immediately -> WAIT_CMD (wall ahead, new command required).
REQ-021 A single down-counter SHALL serve TURN and LEAVE, width 28 bits (fits 2*TURN_CYCLES default); loaded on state entry, no wrap-around.
REQ-022 enable=0 in any state SHALL force IDLE next cycle, clear counter and latched direction, outputs 0; enable has priority over all transitions.
REQ-023 Simultaneous enable=1 and command on same cycle in WAIT_CMD SHALL follow REQ-016.

Reset
REQ-024 rst=1 SHALL on the next clk edge force IDLE, counter 0, latched direction 0, all outputs 0; rst overrides enable.
REQ-025 Reset asserted mid-TURN or mid-LEAVE SHALL abort the manoeuvre with no residual motion output the cycle after reset.

Structure
REQ-026 Command codes (00/01/10/11) and FSM state encodings SHALL live in the shared car-simulation package used by the semi-command stage.
REQ-027 The duration counter SHALL be one sub-module, manoeuvre_timer (load, count, done), reusable by other modes.
REQ-028 No other sub-modules; no combinational path from inputs to outputs.

Verification (TURN_CYCLES=4, LEAVE_CYCLES=3)
REQ-029 rst high 2 cycles, enable=1, det_left=det_right=1, det_front=0 -> CRUISE, move_forward=1 held, cmd_ready=0.
REQ-030 In CRUISE drop det_left to 0 -> WAIT_CMD next cycle, cmd_ready=1, move_forward=0; cmd=10, clockwise=1 one cycle -> turn_right=1 exactly 4 cycles, then move_forward=1 exactly 3 cycles, then CRUISE.
REQ-031 WAIT_CMD, cmd=11, clockwise=0, then flip clockwise to 1 during turn -> turn_left=1 exactly 8 cycles, no turn_right.
REQ-032 WAIT_CMD, cmd=01, assert det_front=1 on 2nd LEAVE cycle -> back to WAIT_CMD next cycle, move_forward=0, cmd_ready=1.
REQ-033 Mid-TURN deassert enable -> all outputs 0 next cycle; re-enable -> CRUISE with full-length timing on next junction.
REQ-034 Mid-LEAVE assert rst -> all outputs 0 next cycle; reset overriding enable=1 checked.
